vga_timing_generator: RTL



---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_timing_generator.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, colour bit positions and coordinate type for the
// 640x480@60 Hz VGA timing generator.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int COLOR_R = 2;
  localparam int COLOR_G = 1;
  localparam int COLOR_B = 0;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter over ACTIVE+FP+SYNC+BP with a registered
// active flag that stays aligned with the count, and a sync window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  output coord_t count,
  output logic   wrap,
  output logic   in_active,
  output logic   in_sync
);

  localparam int     TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END  = coord_t'(ACTIVE);
  localparam coord_t SYNC_BEG = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END = coord_t'(ACTIVE + FP + SYNC);

  coord_t count_q, count_d;
  logic   in_active_q, in_active_d;

  always_comb begin
    wrap    = enable && (count_q == LAST);
    count_d = count_q;
    if (enable) begin
      count_d = wrap ? '0 : count_q + coord_t'(1);
    end
    // Active is derived from the next count so it registers alongside it.
    in_active_d = (count_d < ACT_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      in_active_q <= 1'b1;
    end else begin
      count_q     <= count_d;
      in_active_q <= in_active_d;
    end
  end

  assign count     = count_q;
  assign in_active = in_active_q;
  assign in_sync   = (count_q >= SYNC_BEG) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing top: x/y counters with line/frame strobes, plus a one-cycle
// output stage that blanks colour and keeps sync pins aligned with it.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic         CLOCK_25,
  input  logic         rst_n,
  input  logic [2:0]   color,
  output logic [11:0]  x,
  output logic [11:0]  y,
  output logic         active,
  output logic         line_start,
  output logic         frame_start,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_r,
  output logic         vga_g,
  output logic         vga_b
);

  coord_t h_count, v_count;
  logic   h_wrap, v_wrap;
  logic   h_active, v_active;
  logic   h_sync, v_sync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (CLOCK_25),
    .rst_n     (rst_n),
    .enable    (1'b1),
    .count     (h_count),
    .wrap      (h_wrap),
    .in_active (h_active),
    .in_sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (CLOCK_25),
    .rst_n     (rst_n),
    .enable    (h_wrap),
    .count     (v_count),
    .wrap      (v_wrap),
    .in_active (v_active),
    .in_sync   (v_sync)
  );

  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic r_q, r_d;
  logic g_q, g_d;
  logic b_q, b_d;

  assign active = h_active & v_active;

  always_comb begin
    // v_wrap already requires h_wrap, so frame_start implies line_start.
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    r_d  = active & color[COLOR_R];
    g_d  = active & color[COLOR_G];
    b_d  = active & color[COLOR_B];
    hs_d = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge CLOCK_25) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= ~SYNC_ACTIVE;
      vs_q          <= ~SYNC_ACTIVE;
      r_q           <= 1'b0;
      g_q           <= 1'b0;
      b_q           <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign x           = h_count;
  assign y           = v_count;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule
